dcache_read_arbiter: RTL and testbench

//  Shares the single dCache read port between REQUESTER_NUMBER load reservation stations.

---
 rtl/dcache_read_arbiter_pkg.sv | 18 +
 rtl/dcache_read_arbiter_rr_picker.sv | 29 ++
 rtl/dcache_read_arbiter.sv | 143 ++++++++++++++
 tb/tb_dcache_read_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/dcache_read_arbiter_pkg.sv
// Shared constants and state encoding for the dCache read-port arbiter.
package dcache_read_arbiter_pkg;

  localparam int REQUESTER_NUMBER          = 4;
  localparam int REQUESTER_NUMBER_LOG      = 2;
  localparam int REORDER_BUFFER_SIZE_LOG   = 4;
  localparam int NUMBER_OF_BLOCKS_IN_CACHE = 4;
  localparam int BLOCK_INDEX_LSB           = 4;
  localparam int MAX_WAIT                  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_RETRY = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

endpackage

// File: rtl/dcache_read_arbiter_rr_picker.sv
// Combinational rotate-priority picker: first set request at or after i_ptr, wrapping.
// N must equal 2**LOG so the candidate index wraps naturally.
module dcache_read_arbiter_rr_picker #(
  parameter int N   = 4,
  parameter int LOG = 2
) (
  input  logic [N-1:0]   i_req,
  input  logic [LOG-1:0] i_ptr,
  output logic           o_found,
  output logic [LOG-1:0] o_idx
);

  logic [LOG-1:0] w_cand;

  // Walk from the farthest offset down so the nearest candidate is written last.
  always_comb begin
    o_found = 1'b0;
    o_idx   = '0;
    w_cand  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      w_cand = i_ptr + LOG'(k);
      if (i_req[w_cand]) begin
        o_found = 1'b1;
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/dcache_read_arbiter.sv
// Shares the single dCache read port between load reservation stations, round-robin,
// with retry on a stalled cache and abort on branch flush.
//
// state    | meaning
// ST_IDLE  | no read in flight; arbitrate among eligible stations
// ST_WAIT  | readEnable high, readPtr held, waiting for readSuccess
// ST_RETRY | one-cycle readEnable drop after MAX_WAIT cycles without success
// ST_RESP  | one-cycle response pulse to the winning station
module dcache_read_arbiter
  import dcache_read_arbiter_pkg::*;
#(
  parameter int N   = REQUESTER_NUMBER,
  parameter int LOG = REQUESTER_NUMBER_LOG,
  parameter int RBL = REORDER_BUFFER_SIZE_LOG,
  parameter int NB  = NUMBER_OF_BLOCKS_IN_CACHE,
  parameter int BLI = BLOCK_INDEX_LSB,
  parameter int MW  = MAX_WAIT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            flush,
  input  logic [N-1:0]    req_valid,
  input  logic [N*32-1:0] req_addr,
  input  logic [N*RBL-1:0] req_pos,
  output logic [N-1:0]    req_grant,
  output logic [N-1:0]    resp_valid,
  output logic [31:0]     resp_value,
  output logic [RBL-1:0]  resp_pos,
  output logic [31:0]     dCache_readPtr,
  output logic            dCache_readEnable,
  input  logic [31:0]     dCache_readValue,
  input  logic            dCache_readSuccess,
  input  logic [NB-1:0]   dCache_busy
);

  localparam int NBL = $clog2(NB);
  localparam int WCW = $clog2(MW);

  arb_state_t     r_state, w_state_nxt;
  logic [WCW-1:0] r_wait_cnt, w_wait_cnt_nxt;
  logic [LOG-1:0] r_rr_ptr, r_id;
  logic [31:0]    r_addr, r_value;
  logic [RBL-1:0] r_pos;
  logic           r_first;

  logic [N-1:0]   w_eligible;
  logic           w_found;
  logic [LOG-1:0] w_win_idx;
  logic           w_accept;

  always_comb begin
    w_eligible = '0;
    for (int i = 0; i < N; i++)
      w_eligible[i] = req_valid[i] && !dCache_busy[req_addr[32*i+BLI +: NBL]];
  end

  dcache_read_arbiter_rr_picker #(.N(N), .LOG(LOG)) u_picker (
    .i_req   (w_eligible),
    .i_ptr   (r_rr_ptr),
    .o_found (w_found),
    .o_idx   (w_win_idx)
  );

  assign w_accept = (r_state == ST_IDLE) && w_found && !flush;

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt    = ST_WAIT;
          w_wait_cnt_nxt = '0;
        end
      end
      ST_WAIT: begin
        if (dCache_readSuccess)
          w_state_nxt = ST_RESP;
        else if (r_wait_cnt == WCW'(MW - 1))
          w_state_nxt = ST_RETRY;
        else
          w_wait_cnt_nxt = r_wait_cnt + WCW'(1);
      end
      ST_RETRY: begin
        w_state_nxt    = ST_WAIT;
        w_wait_cnt_nxt = '0;
      end
      ST_RESP:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
    // Flush wins over everything, including a same-cycle readSuccess.
    if (flush) begin
      w_state_nxt    = ST_IDLE;
      w_wait_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
      r_rr_ptr   <= '0;
      r_id       <= '0;
      r_addr     <= '0;
      r_pos      <= '0;
      r_value    <= '0;
      r_first    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
      r_first    <= w_accept;
      if (w_accept) begin
        r_id   <= w_win_idx;
        r_addr <= req_addr[32*w_win_idx +: 32];
        r_pos  <= req_pos[RBL*w_win_idx +: RBL];
      end
      if (r_state == ST_WAIT && dCache_readSuccess)
        r_value <= dCache_readValue;
      if (r_state == ST_RESP && !flush)
        r_rr_ptr <= (r_id == LOG'(N - 1)) ? '0 : r_id + LOG'(1);
    end
  end

  always_comb begin
    dCache_readEnable = (r_state == ST_WAIT) && !flush;
    dCache_readPtr    = dCache_readEnable ? r_addr : '0;
    req_grant         = (r_first && r_state == ST_WAIT && !flush) ? (N'(1) << r_id) : '0;
    resp_valid        = '0;
    resp_value        = '0;
    resp_pos          = '0;
    if (r_state == ST_RESP && !flush) begin
      resp_valid = N'(1) << r_id;
      resp_value = r_value;
      resp_pos   = r_pos;
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (!reset) $onehot0(req_grant));
  a_resp_onehot:  assert property (@(posedge clk) disable iff (!reset) $onehot0(resp_valid));
  a_ptr_stable:   assert property (@(posedge clk) disable iff (!reset)
                    (dCache_readEnable && $past(dCache_readEnable)) |-> $stable(dCache_readPtr));

endmodule

// File: tb/tb_dcache_read_arbiter.sv
// Directed bench for dcache_read_arbiter: reset, single load, fairness, busy skip,
// retry after timeout, and flush.
module tb_dcache_read_arbiter;

  localparam int N   = 4;
  localparam int RBL = 4;
  localparam int NB  = 4;

  logic            clk;
  logic            reset;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N*32-1:0] req_addr;
  logic [N*RBL-1:0] req_pos;
  logic [N-1:0]    req_grant;
  logic [N-1:0]    resp_valid;
  logic [31:0]     resp_value;
  logic [RBL-1:0]  resp_pos;
  logic [31:0]     dCache_readPtr;
  logic            dCache_readEnable;
  logic [31:0]     dCache_readValue;
  logic            dCache_readSuccess;
  logic [NB-1:0]   dCache_busy;

  int n_checks = 0;
  int n_errors = 0;

  dcache_read_arbiter dut (
    .clk                (clk),
    .reset              (reset),
    .flush              (flush),
    .req_valid          (req_valid),
    .req_addr           (req_addr),
    .req_pos            (req_pos),
    .req_grant          (req_grant),
    .resp_valid         (resp_valid),
    .resp_value         (resp_value),
    .resp_pos           (resp_pos),
    .dCache_readPtr     (dCache_readPtr),
    .dCache_readEnable  (dCache_readEnable),
    .dCache_readValue   (dCache_readValue),
    .dCache_readSuccess (dCache_readSuccess),
    .dCache_busy        (dCache_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [RBL-1:0] p);
    req_addr[32*i +: 32] = a;
    req_pos[RBL*i +: RBL] = p;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; flush = 1'b0; req_valid = '0; req_addr = '0; req_pos = '0;
    dCache_readValue = '0; dCache_readSuccess = 1'b0; dCache_busy = '0;
    do_reset();
    check_eq("rst_en",    32'(dCache_readEnable), 32'd0);
    check_eq("rst_ptr",   dCache_readPtr,         32'd0);
    check_eq("rst_grant", 32'(req_grant),         32'd0);
    check_eq("rst_resp",  32'(resp_valid),        32'd0);

    // Single load from station 2
    set_req(2, 32'd12, 4'd3);
    req_valid = 4'b0100;
    check_eq("t2_idle_grant", 32'(req_grant), 32'd0);
    tick();
    check_eq("t2_grant", 32'(req_grant),         32'b0100);
    check_eq("t2_ptr",   dCache_readPtr,         32'd12);
    check_eq("t2_en",    32'(dCache_readEnable), 32'd1);
    req_valid = '0;
    tick();
    check_eq("t2_grant_pulse", 32'(req_grant), 32'd0);
    tick();
    dCache_readSuccess = 1'b1; dCache_readValue = 32'd5;
    check_eq("t2_no_early_resp", 32'(resp_valid), 32'd0);
    tick();
    dCache_readSuccess = 1'b0;
    check_eq("t2_resp",  32'(resp_valid),        32'b0100);
    check_eq("t2_value", resp_value,             32'd5);
    check_eq("t2_pos",   32'(resp_pos),          32'd3);
    check_eq("t2_en_resp", 32'(dCache_readEnable), 32'd0);
    tick();
    check_eq("t2_resp_pulse", 32'(resp_valid), 32'd0);

    // Reset mid-WAIT; afterwards the pointer is back at station 0
    set_req(3, 32'h40, 4'd1);
    req_valid = 4'b1000;
    tick();
    check_eq("t1_grant", 32'(req_grant), 32'b1000);
    req_valid = '0;
    tick();
    reset = 1'b0;
    #1;
    check_eq("t1_en",    32'(dCache_readEnable), 32'd0);
    check_eq("t1_ptr",   dCache_readPtr,         32'd0);
    check_eq("t1_grant0", 32'(req_grant),        32'd0);
    check_eq("t1_resp0", 32'(resp_valid),        32'd0);
    #2;
    reset = 1'b1;
    set_req(0, 32'h100, 4'd6);
    req_valid = 4'b1001;
    tick();
    check_eq("t1_restart_grant", 32'(req_grant), 32'b0001);
    check_eq("t1_restart_ptr",   dCache_readPtr, 32'h100);
    req_valid = '0;
    dCache_readSuccess = 1'b1; dCache_readValue = 32'hAA;
    tick();
    dCache_readSuccess = 1'b0;
    check_eq("t1_resp",  32'(resp_valid), 32'b0001);
    check_eq("t1_value", resp_value,      32'hAA);
    tick();

    // Fairness: everyone requesting, cache answers right away
    do_reset();
    for (int i = 0; i < N; i++) set_req(i, 32'h200 + 32'(i) * 32'h40, 4'(i + 8));
    req_valid = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      check_eq($sformatf("t3_grant%0d", k), 32'(req_grant), 32'(1) << (k % 4));
      dCache_readSuccess = 1'b1; dCache_readValue = 32'h1000 + 32'(k);
      tick();
      dCache_readSuccess = 1'b0;
      check_eq($sformatf("t3_resp%0d", k), 32'(resp_valid), 32'(1) << (k % 4));
      check_eq($sformatf("t3_pos%0d", k),  32'(resp_pos),   32'((k % 4) + 8));
      check_eq($sformatf("t3_val%0d", k),  resp_value,      32'h1000 + 32'(k));
      tick();
      tick();
    end
    req_valid = '0;
    tick();
    tick();

    // Busy skip: station 0 targets busy block 1, station 2 goes first
    do_reset();
    set_req(0, 32'h10, 4'd4);
    set_req(2, 32'h20, 4'd5);
    dCache_busy = 4'b0010;
    req_valid = 4'b0101;
    tick();
    check_eq("t4_grant2", 32'(req_grant),   32'b0100);
    check_eq("t4_ptr2",   dCache_readPtr,   32'h20);
    req_valid = 4'b0001;
    dCache_readSuccess = 1'b1; dCache_readValue = 32'h22;
    tick();
    dCache_readSuccess = 1'b0;
    check_eq("t4_resp2", 32'(resp_valid), 32'b0100);
    tick();
    tick();
    check_eq("t4_blocked", 32'(req_grant),         32'd0);
    check_eq("t4_idle_en", 32'(dCache_readEnable), 32'd0);
    dCache_busy = '0;
    tick();
    check_eq("t4_grant0", 32'(req_grant), 32'b0001);
    check_eq("t4_ptr0",   dCache_readPtr, 32'h10);
    dCache_busy = 4'b0010;
    req_valid = '0;
    dCache_readSuccess = 1'b1; dCache_readValue = 32'h33;
    tick();
    dCache_readSuccess = 1'b0;
    dCache_busy = '0;
    check_eq("t4_resp0", 32'(resp_valid), 32'b0001);
    check_eq("t4_val0",  resp_value,      32'h33);
    check_eq("t4_pos0",  32'(resp_pos),   32'd4);
    tick();

    // Timeout: 8 WAIT cycles, 1 RETRY cycle, then success
    set_req(1, 32'h80, 4'd7);
    req_valid = 4'b0010;
    tick();
    check_eq("t5_grant", 32'(req_grant), 32'b0010);
    req_valid = '0;
    for (int k = 1; k < 8; k++) begin
      tick();
      check_eq($sformatf("t5_wait%0d", k), 32'(dCache_readEnable), 32'd1);
    end
    tick();
    check_eq("t5_retry_en",    32'(dCache_readEnable), 32'd0);
    check_eq("t5_retry_resp",  32'(resp_valid),        32'd0);
    tick();
    check_eq("t5_rewait_en",    32'(dCache_readEnable), 32'd1);
    check_eq("t5_rewait_ptr",   dCache_readPtr,         32'h80);
    check_eq("t5_rewait_grant", 32'(req_grant),         32'd0);
    dCache_readSuccess = 1'b1; dCache_readValue = 32'h55;
    tick();
    dCache_readSuccess = 1'b0;
    check_eq("t5_resp",  32'(resp_valid), 32'b0010);
    check_eq("t5_value", resp_value,      32'h55);
    check_eq("t5_pos",   32'(resp_pos),   32'd7);
    tick();
    check_eq("t5_single_resp", 32'(resp_valid), 32'd0);

    // Flush with same-cycle success, then flush in IDLE blocking a grant
    set_req(2, 32'h30, 4'd9);
    req_valid = 4'b0100;
    tick();
    check_eq("t6_grant", 32'(req_grant), 32'b0100);
    req_valid = '0;
    dCache_readSuccess = 1'b1; dCache_readValue = 32'h66;
    flush = 1'b1;
    #1;
    check_eq("t6_flush_en", 32'(dCache_readEnable), 32'd0);
    tick();
    flush = 1'b0;
    dCache_readSuccess = 1'b0;
    check_eq("t6_no_resp", 32'(resp_valid),        32'd0);
    check_eq("t6_idle_en", 32'(dCache_readEnable), 32'd0);
    tick();
    check_eq("t6_still_no_resp", 32'(resp_valid), 32'd0);
    set_req(0, 32'h40, 4'd2);
    req_valid = 4'b0001;
    flush = 1'b1;
    tick();
    check_eq("t6_flush_idle_grant", 32'(req_grant),         32'd0);
    check_eq("t6_flush_idle_en",    32'(dCache_readEnable), 32'd0);
    flush = 1'b0;
    tick();
    check_eq("t6_next_grant", 32'(req_grant), 32'b0001);
    check_eq("t6_next_ptr",   dCache_readPtr, 32'h40);
    req_valid = '0;
    dCache_readSuccess = 1'b1; dCache_readValue = 32'h77;
    tick();
    dCache_readSuccess = 1'b0;
    check_eq("t6_next_resp",  32'(resp_valid), 32'b0001);
    check_eq("t6_next_value", resp_value,      32'h77);
    check_eq("t6_next_pos",   32'(resp_pos),   32'd2);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
